// File: rtl/ddr_ctrl_wr_burst_pkg.sv
// Shared definitions for the SDRAM write burst engine: command encodings,
// FSM state encoding and the timer width used by the recovery counters.
package ddr_ctrl_wr_burst_pkg;

    // SDRAM commands as {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_BST   = 4'b0110;
    localparam logic [3:0] CMD_PRE   = 4'b0010;

    // Width of the shared delay counter; covers tRCD/tWR/tRP up to 256 clocks
    localparam int TMR_W = 8;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_PRE_MISS = 4'd1,
        ST_TRP_MISS = 4'd2,
        ST_ACTIVE   = 4'd3,
        ST_TRCD     = 4'd4,
        ST_WRITE    = 4'd5,
        ST_DATA     = 4'd6,
        ST_BST      = 4'd7,
        ST_TWR      = 4'd8,
        ST_PRE      = 4'd9,
        ST_TRP      = 4'd10,
        ST_END      = 4'd11
    } state_t;

    // A wait phase of N clocks is spent as N cycles in its state, so the
    // counter is loaded with N-1 and the state is left when it reaches zero.
    function automatic logic [TMR_W-1:0] tmr_load(input int clk_cnt);
        return (clk_cnt > 0) ? TMR_W'(clk_cnt - 1) : '0;
    endfunction

endpackage

// File: rtl/ddr_wr_timer.sv
// Loadable down-counter with a done flag. One instance is shared by every
// wait phase of the write engine, since only one phase is ever active.
module ddr_wr_timer
    import ddr_ctrl_wr_burst_pkg::*;
(
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             done
);

    logic [TMR_W-1:0] cnt_reg;

    // Count down to zero and hold there until the next load
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign done = (cnt_reg == '0);

endmodule

// File: rtl/ddr_ctrl_wr_burst.sv
// SDRAM write burst engine: ACT -> WRITE -> data beats -> BST -> tWR -> PRE,
// splitting requests that cross a row boundary into per-row segments.
// Optional macro SDRAM_WR_OPEN_ROW_EN keeps the last row open between
// requests and skips ACT on a row hit.
// Wait parameters may be 0, in which case the matching wait state is skipped.
module ddr_ctrl_wr_burst
    import ddr_ctrl_wr_burst_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int BA_WIDTH   = 2,
    parameter int ROW_WIDTH  = 13,
    parameter int COL_WIDTH  = 9,
    parameter int ADDR_WIDTH = 13,
    parameter int LEN_WIDTH  = 10,
    parameter int TRCD_CLK   = 2,
    parameter int TWR_CLK    = 2,
    parameter int TRP_CLK    = 2
)
(
    input  logic                                   sys_clk,
    input  logic                                   sys_rst,
    input  logic                                   init_end_i,
    input  logic                                   wr_en_i,
    input  logic [BA_WIDTH+ROW_WIDTH+COL_WIDTH-1:0] wr_addr_i,
    input  logic [LEN_WIDTH-1:0]                   wr_burst_len_i,
    input  logic [DATA_WIDTH-1:0]                  wr_data_i,
    input  logic                                   wr_row_close_i,
    output logic                                   wr_ack_o,
    output logic                                   wr_end_o,
    output logic [3:0]                             wr_cmd_o,
    output logic [BA_WIDTH-1:0]                    wr_ba_o,
    output logic [ADDR_WIDTH-1:0]                  wr_addr_o,
    output logic                                   wr_sdram_en_o,
    output logic [DATA_WIDTH-1:0]                  wr_sdram_data_o,
    output logic [DATA_WIDTH/8-1:0]                wr_dqm_o
);

    localparam int LA_W = BA_WIDTH + ROW_WIDTH + COL_WIDTH;
    localparam int DM_W = DATA_WIDTH / 8;

    state_t                 state_reg, state_next;
    logic [LA_W-1:0]        cur_addr_reg, cur_addr_next;
    logic [LEN_WIDTH-1:0]   remaining_reg, remaining_next;
    logic [BA_WIDTH-1:0]    seg_ba_reg, seg_ba_next;
    logic [ROW_WIDTH-1:0]   seg_row_reg, seg_row_next;

    logic [3:0]             cmd_reg, cmd_next;
    logic [BA_WIDTH-1:0]    ba_reg, ba_next;
    logic [ADDR_WIDTH-1:0]  addr_reg, addr_next;
    logic                   en_reg, en_next;
    logic [DATA_WIDTH-1:0]  data_reg, data_next;
    logic [DM_W-1:0]        dqm_reg, dqm_next;
    logic                   end_reg, end_next;

    logic [BA_WIDTH-1:0]    cur_ba, req_ba;
    logic [ROW_WIDTH-1:0]   cur_row, req_row;
    logic [COL_WIDTH-1:0]   cur_col;
    logic                   req_accept, last_beat, more_left, row_hit;
    logic                   tmr_load_en, tmr_done;
    logic [TMR_W-1:0]       tmr_load_val;
    state_t                 after_twr, after_trp;

    logic                   open_valid;
    logic [BA_WIDTH-1:0]    open_ba;
    logic [ROW_WIDTH-1:0]   open_row;

    assign cur_ba  = cur_addr_reg[LA_W-1 -: BA_WIDTH];
    assign cur_row = cur_addr_reg[COL_WIDTH +: ROW_WIDTH];
    assign cur_col = cur_addr_reg[COL_WIDTH-1:0];
    assign req_ba  = wr_addr_i[LA_W-1 -: BA_WIDTH];
    assign req_row = wr_addr_i[COL_WIDTH +: ROW_WIDTH];

    assign req_accept = (state_reg == ST_IDLE) && wr_en_i && init_end_i;
    // A segment ends on the request's final beat or on the last column of the row
    assign last_beat  = (remaining_reg == LEN_WIDTH'(1)) || (cur_col == '1);
    assign more_left  = (remaining_reg != '0);
    assign row_hit    = open_valid && (req_ba == open_ba) && (req_row == open_row);

`ifdef SDRAM_WR_OPEN_ROW_EN
    localparam bit OPEN_ROW = 1'b1;

    logic                 open_valid_reg;
    logic [BA_WIDTH-1:0]  open_ba_reg;
    logic [ROW_WIDTH-1:0] open_row_reg;
    logic                 row_keep;

    // The final segment leaves its row open instead of precharging it
    assign row_keep = (state_next == ST_END) &&
                      ((state_reg == ST_BST) || (state_reg == ST_TWR));

    // Track the open bank/row; an external close wins over a same-cycle open
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            open_valid_reg <= 1'b0;
            open_ba_reg    <= '0;
            open_row_reg   <= '0;
        end else if (wr_row_close_i) begin
            open_valid_reg <= 1'b0;
        end else if (row_keep) begin
            open_valid_reg <= 1'b1;
            open_ba_reg    <= seg_ba_reg;
            open_row_reg   <= seg_row_reg;
        end else if ((state_reg == ST_PRE) || (state_reg == ST_PRE_MISS)) begin
            open_valid_reg <= 1'b0;
        end
    end

    assign open_valid = open_valid_reg && !wr_row_close_i;
    assign open_ba    = open_ba_reg;
    assign open_row   = open_row_reg;
`else
    localparam bit OPEN_ROW = 1'b0;

    logic unused_row_close;

    assign unused_row_close = wr_row_close_i;
    assign open_valid       = 1'b0;
    assign open_ba          = '0;
    assign open_row         = '0;
`endif

    assign after_twr = (OPEN_ROW && !more_left) ? ST_END : ST_PRE;
    assign after_trp = more_left ? ST_ACTIVE : ST_END;

    // Delay counter is (re)loaded in the state that precedes each wait phase
    always_comb begin
        tmr_load_en  = 1'b0;
        tmr_load_val = '0;
        case (state_reg)
            ST_ACTIVE:   begin tmr_load_en = 1'b1; tmr_load_val = tmr_load(TRCD_CLK); end
            ST_BST:      begin tmr_load_en = 1'b1; tmr_load_val = tmr_load(TWR_CLK);  end
            ST_PRE,
            ST_PRE_MISS: begin tmr_load_en = 1'b1; tmr_load_val = tmr_load(TRP_CLK);  end
            default:     ;
        endcase
    end

    ddr_wr_timer u_timer (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .load     (tmr_load_en),
        .load_val (tmr_load_val),
        .done     (tmr_done)
    );

    // FSM state register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_accept) begin
                    if (wr_burst_len_i == '0)  state_next = ST_END;
                    else if (row_hit)          state_next = ST_WRITE;
                    else if (open_valid)       state_next = ST_PRE_MISS;
                    else                       state_next = ST_ACTIVE;
                end
            end
            ST_PRE_MISS: state_next = (TRP_CLK == 0) ? ST_ACTIVE : ST_TRP_MISS;
            ST_TRP_MISS: if (tmr_done) state_next = ST_ACTIVE;
            ST_ACTIVE:   state_next = (TRCD_CLK == 0) ? ST_WRITE : ST_TRCD;
            ST_TRCD:     if (tmr_done) state_next = ST_WRITE;
            ST_WRITE,
            ST_DATA:     state_next = last_beat ? ST_BST : ST_DATA;
            ST_BST:      state_next = (TWR_CLK == 0) ? after_twr : ST_TWR;
            ST_TWR:      if (tmr_done) state_next = after_twr;
            ST_PRE:      state_next = (TRP_CLK == 0) ? after_trp : ST_TRP;
            ST_TRP:      if (tmr_done) state_next = after_trp;
            ST_END:      state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    // Address/length bookkeeping: one linear step per consumed beat
    always_comb begin
        cur_addr_next  = cur_addr_reg;
        remaining_next = remaining_reg;
        seg_ba_next    = seg_ba_reg;
        seg_row_next   = seg_row_reg;
        if (req_accept) begin
            cur_addr_next  = wr_addr_i;
            remaining_next = wr_burst_len_i;
        end else if ((state_reg == ST_WRITE) || (state_reg == ST_DATA)) begin
            cur_addr_next  = cur_addr_reg + 1'b1;
            remaining_next = remaining_reg - 1'b1;
        end
        if (state_reg == ST_WRITE) begin
            seg_ba_next  = cur_ba;
            seg_row_next = cur_row;
        end
    end

    // Datapath registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cur_addr_reg  <= '0;
            remaining_reg <= '0;
            seg_ba_reg    <= '0;
            seg_row_reg   <= '0;
        end else begin
            cur_addr_reg  <= cur_addr_next;
            remaining_reg <= remaining_next;
            seg_ba_reg    <= seg_ba_next;
            seg_row_reg   <= seg_row_next;
        end
    end

    // FSM output decode, registered one cycle later onto the SDRAM bus
    always_comb begin
        cmd_next  = CMD_NOP;
        ba_next   = '1;
        addr_next = '1;
        en_next   = 1'b0;
        data_next = '0;
        dqm_next  = '1;
        end_next  = 1'b0;
        case (state_reg)
            ST_ACTIVE: begin
                cmd_next  = CMD_ACT;
                ba_next   = cur_ba;
                addr_next = ADDR_WIDTH'(cur_row);
            end
            ST_WRITE: begin
                cmd_next  = CMD_WRITE;
                ba_next   = cur_ba;
                addr_next = ADDR_WIDTH'(cur_col);
                en_next   = 1'b1;
                data_next = wr_data_i;
                dqm_next  = '0;
            end
            ST_DATA: begin
                en_next   = 1'b1;
                data_next = wr_data_i;
                dqm_next  = '0;
            end
            ST_BST: begin
                cmd_next  = CMD_BST;
            end
            ST_PRE: begin
                cmd_next  = CMD_PRE;
                ba_next   = seg_ba_reg;
                addr_next = '0;
            end
            ST_PRE_MISS: begin
                cmd_next  = CMD_PRE;
                ba_next   = open_ba;
                addr_next = '0;
            end
            ST_END: begin
                end_next  = 1'b1;
            end
            default: ;
        endcase
    end

    // Bus output registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cmd_reg  <= CMD_NOP;
            ba_reg   <= '1;
            addr_reg <= '1;
            en_reg   <= 1'b0;
            data_reg <= '0;
            dqm_reg  <= '1;
            end_reg  <= 1'b0;
        end else begin
            cmd_reg  <= cmd_next;
            ba_reg   <= ba_next;
            addr_reg <= addr_next;
            en_reg   <= en_next;
            data_reg <= data_next;
            dqm_reg  <= dqm_next;
            end_reg  <= end_next;
        end
    end

    // Data is pulled one cycle ahead of the bus beat it lands on
    assign wr_ack_o        = (state_reg == ST_WRITE) || (state_reg == ST_DATA);
    assign wr_end_o        = end_reg;
    assign wr_cmd_o        = cmd_reg;
    assign wr_ba_o         = ba_reg;
    assign wr_addr_o       = addr_reg;
    assign wr_sdram_en_o   = en_reg;
    assign wr_sdram_data_o = data_reg;
    assign wr_dqm_o        = dqm_reg;

endmodule

// File: tb/tb_ddr_ctrl_wr_burst.sv
// Directed bench for ddr_ctrl_wr_burst with default parameters. Cycle 0 of a
// request is the cycle in which wr_en_i is high; all logged cycle numbers are
// relative to it.
module tb_ddr_ctrl_wr_burst;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] WRC = 4'b0100;
    localparam logic [3:0] BST = 4'b0110;
    localparam logic [3:0] PRE = 4'b0010;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        init_end_i;
    logic        wr_en_i;
    logic [23:0] wr_addr_i;
    logic [9:0]  wr_burst_len_i;
    logic [15:0] wr_data_i;
    logic        wr_row_close_i;
    logic        wr_ack_o;
    logic        wr_end_o;
    logic [3:0]  wr_cmd_o;
    logic [1:0]  wr_ba_o;
    logic [12:0] wr_addr_o;
    logic        wr_sdram_en_o;
    logic [15:0] wr_sdram_data_o;
    logic [1:0]  wr_dqm_o;

    always #5 sys_clk = ~sys_clk;

    ddr_ctrl_wr_burst #(
        .DATA_WIDTH(16), .BA_WIDTH(2), .ROW_WIDTH(13), .COL_WIDTH(9),
        .ADDR_WIDTH(13), .LEN_WIDTH(10), .TRCD_CLK(2), .TWR_CLK(2), .TRP_CLK(2)
    ) dut (
        .sys_clk         (sys_clk),
        .sys_rst         (sys_rst),
        .init_end_i      (init_end_i),
        .wr_en_i         (wr_en_i),
        .wr_addr_i       (wr_addr_i),
        .wr_burst_len_i  (wr_burst_len_i),
        .wr_data_i       (wr_data_i),
        .wr_row_close_i  (wr_row_close_i),
        .wr_ack_o        (wr_ack_o),
        .wr_end_o        (wr_end_o),
        .wr_cmd_o        (wr_cmd_o),
        .wr_ba_o         (wr_ba_o),
        .wr_addr_o       (wr_addr_o),
        .wr_sdram_en_o   (wr_sdram_en_o),
        .wr_sdram_data_o (wr_sdram_data_o),
        .wr_dqm_o        (wr_dqm_o)
    );

    int          total = 0;
    int          bad   = 0;
    int          cyc_rel;
    int          ack_n;
    int          mask_err;
    logic [15:0] dbase;
    logic [39:0] cmd_q[$];
    logic [15:0] beat_q[$];
    int          beat_cyc_q[$];
    int          end_q[$];

    function automatic logic [39:0] ev(input logic [3:0] c, input int cy,
                                       input logic [1:0] b, input logic [12:0] a);
        return {c, 16'(cy), 2'b00, b, 3'b000, a};
    endfunction

    task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
            $error("check %s differs", tag);
        end
    endtask

    // Compare the idx-th logged command; when full=0 only cmd and cycle matter
    task automatic chk_ev(input string tag, input int idx, input logic [39:0] exp, input bit full);
        logic [39:0] got;
        logic [39:0] m;
        got = (idx < cmd_q.size()) ? cmd_q[idx] : 40'hx;
        m   = full ? 40'hFF_FFFF_FFFF : 40'hFF_FFF0_0000;
        chk(tag, got & m, exp & m);
    endtask

    task automatic chk_beat(input string tag, input int idx, input int exp_cyc, input logic [15:0] exp_dat);
        int          gc;
        logic [15:0] gd;
        gc = (idx < beat_cyc_q.size()) ? beat_cyc_q[idx] : -1;
        gd = (idx < beat_q.size()) ? beat_q[idx] : 16'hx;
        chk(tag, {8'h0, 16'(gc), gd}, {8'h0, 16'(exp_cyc), exp_dat});
    endtask

    task automatic chk_end(input string tag, input int exp_cyc);
        int g;
        g = (end_q.size() > 0) ? end_q[0] : -1;
        chk({tag, " end count"}, 40'(end_q.size()), 40'd1);
        chk({tag, " end cycle"}, 40'(g), 40'(exp_cyc));
    endtask

    // Record bus activity of the current cycle and serve write data on ack
    task automatic log_cycle();
        if (wr_cmd_o !== NOP) cmd_q.push_back(ev(wr_cmd_o, cyc_rel, wr_ba_o, wr_addr_o));
        if (wr_sdram_en_o === 1'b1) begin
            beat_q.push_back(wr_sdram_data_o);
            beat_cyc_q.push_back(cyc_rel);
        end
        if (wr_dqm_o !== (wr_sdram_en_o ? 2'b00 : 2'b11)) mask_err++;
        if (!wr_sdram_en_o && wr_sdram_data_o !== 16'h0) mask_err++;
        if (wr_end_o === 1'b1) end_q.push_back(cyc_rel);
        wr_data_i = dbase + 16'(ack_n);
        if (wr_ack_o === 1'b1) ack_n++;
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
        cyc_rel++;
        log_cycle();
    endtask

    task automatic run_req(input logic [23:0] addr, input logic [9:0] len,
                           input logic [15:0] base, input int ncyc);
        wr_addr_i      = addr;
        wr_burst_len_i = len;
        wr_en_i        = 1'b1;
        dbase          = base;
        cyc_rel        = 0;
        ack_n          = 0;
        mask_err       = 0;
        cmd_q.delete();
        beat_q.delete();
        beat_cyc_q.delete();
        end_q.delete();
        log_cycle();
        step();
        wr_en_i = 1'b0;
        repeat (ncyc - 1) step();
    endtask

    initial begin
        sys_rst        = 1'b1;
        init_end_i     = 1'b1;
        wr_en_i        = 1'b0;
        wr_addr_i      = '0;
        wr_burst_len_i = '0;
        wr_data_i      = '0;
        wr_row_close_i = 1'b0;
        dbase          = '0;
        cyc_rel        = 0;
        ack_n          = 0;
        mask_err       = 0;
        repeat (3) step();

        // Reset state of every output
        chk("rst cmd",  40'(wr_cmd_o), 40'(NOP));
        chk("rst ba",   40'(wr_ba_o), 40'h3);
        chk("rst addr", 40'(wr_addr_o), 40'h1FFF);
        chk("rst en",   40'(wr_sdram_en_o), 40'h0);
        chk("rst data", 40'(wr_sdram_data_o), 40'h0);
        chk("rst dqm",  40'(wr_dqm_o), 40'h3);
        chk("rst ack",  40'(wr_ack_o), 40'h0);
        chk("rst end",  40'(wr_end_o), 40'h0);
        sys_rst = 1'b0;
        repeat (2) step();

`ifdef SDRAM_WR_OPEN_ROW_EN
        // First request opens row 0 and leaves it open
        run_req(24'h000010, 10'd4, 16'hA000, 16);
        chk("o1 ncmd", 40'(cmd_q.size()), 40'd3);
        chk_ev("o1 act", 0, ev(ACT, 2, 2'd0, 13'h0), 1'b1);
        chk_ev("o1 wr",  1, ev(WRC, 5, 2'd0, 13'h010), 1'b1);
        chk_ev("o1 bst", 2, ev(BST, 9, 2'd0, 13'h0), 1'b0);
        chk_end("o1", 12);

        // Row hit: WRITE at cycle 2, no ACT
        run_req(24'h000020, 10'd2, 16'hB000, 12);
        chk("o2 ncmd", 40'(cmd_q.size()), 40'd2);
        chk_ev("o2 wr",  0, ev(WRC, 2, 2'd0, 13'h020), 1'b1);
        chk_ev("o2 bst", 1, ev(BST, 4, 2'd0, 13'h0), 1'b0);
        chk_beat("o2 beat0", 0, 2, 16'hB000);
        chk_beat("o2 beat1", 1, 3, 16'hB001);
        chk("o2 acks", 40'(ack_n), 40'd2);
        chk_end("o2", 7);

        // Row miss: precharge the open row, then activate the new one
        run_req(24'h000200, 10'd1, 16'hC000, 16);
        chk("o3 ncmd", 40'(cmd_q.size()), 40'd4);
        chk_ev("o3 pre", 0, ev(PRE, 2, 2'd0, 13'h0), 1'b1);
        chk_ev("o3 act", 1, ev(ACT, 5, 2'd0, 13'h1), 1'b1);
        chk_ev("o3 wr",  2, ev(WRC, 8, 2'd0, 13'h0), 1'b1);
        chk_end("o3", 12);

        // External close between requests: ACT without PRE
        wr_row_close_i = 1'b1;
        step();
        wr_row_close_i = 1'b0;
        step();
        run_req(24'h000200, 10'd1, 16'hD000, 14);
        chk("o4 ncmd", 40'(cmd_q.size()), 40'd3);
        chk_ev("o4 act", 0, ev(ACT, 2, 2'd0, 13'h1), 1'b1);
        chk_ev("o4 wr",  1, ev(WRC, 5, 2'd0, 13'h0), 1'b1);
        chk_end("o4", 9);
        chk("o mask", 40'(mask_err), 40'd0);
`else
        // Close-page single segment
        run_req(24'h000010, 10'd4, 16'hA000, 20);
        chk("t1 ncmd", 40'(cmd_q.size()), 40'd4);
        chk_ev("t1 act", 0, ev(ACT, 2, 2'd0, 13'h0), 1'b1);
        chk_ev("t1 wr",  1, ev(WRC, 5, 2'd0, 13'h010), 1'b1);
        chk_ev("t1 bst", 2, ev(BST, 9, 2'd0, 13'h0), 1'b0);
        chk_ev("t1 pre", 3, ev(PRE, 12, 2'd0, 13'h0), 1'b1);
        chk("t1 acks", 40'(ack_n), 40'd4);
        chk("t1 beats", 40'(beat_q.size()), 40'd4);
        chk_beat("t1 beat0", 0, 5, 16'hA000);
        chk_beat("t1 beat3", 3, 8, 16'hA003);
        chk("t1 mask", 40'(mask_err), 40'd0);
        chk_end("t1", 15);

        // Page split: 2 beats in row 5, 3 beats in row 6
        run_req(24'h000BFE, 10'd5, 16'hB000, 30);
        chk("t2 ncmd", 40'(cmd_q.size()), 40'd8);
        chk_ev("t2 act0", 0, ev(ACT, 2, 2'd0, 13'h5), 1'b1);
        chk_ev("t2 wr0",  1, ev(WRC, 5, 2'd0, 13'h1FE), 1'b1);
        chk_ev("t2 bst0", 2, ev(BST, 7, 2'd0, 13'h0), 1'b0);
        chk_ev("t2 pre0", 3, ev(PRE, 10, 2'd0, 13'h0), 1'b1);
        chk_ev("t2 act1", 4, ev(ACT, 13, 2'd0, 13'h6), 1'b1);
        chk_ev("t2 wr1",  5, ev(WRC, 16, 2'd0, 13'h0), 1'b1);
        chk_ev("t2 bst1", 6, ev(BST, 19, 2'd0, 13'h0), 1'b0);
        chk_ev("t2 pre1", 7, ev(PRE, 22, 2'd0, 13'h0), 1'b1);
        chk("t2 acks", 40'(ack_n), 40'd5);
        chk_beat("t2 beat1", 1, 6, 16'hB001);
        chk_beat("t2 beat2", 2, 16, 16'hB002);
        chk_beat("t2 beat4", 4, 18, 16'hB004);
        chk("t2 mask", 40'(mask_err), 40'd0);
        chk_end("t2", 25);

        // Zero length: only an end pulse
        run_req(24'h0A5123, 10'd0, 16'hF000, 6);
        chk("t3 ncmd", 40'(cmd_q.size()), 40'd0);
        chk("t3 acks", 40'(ack_n), 40'd0);
        chk_end("t3", 2);

        // Reset in the middle of the data phase
        run_req(24'h000040, 10'd4, 16'hC000, 8);
        sys_rst = 1'b1;
        step();
        chk("t4 cmd",  40'(wr_cmd_o), 40'(NOP));
        chk("t4 ba",   40'(wr_ba_o), 40'h3);
        chk("t4 addr", 40'(wr_addr_o), 40'h1FFF);
        chk("t4 en",   40'(wr_sdram_en_o), 40'h0);
        chk("t4 data", 40'(wr_sdram_data_o), 40'h0);
        chk("t4 dqm",  40'(wr_dqm_o), 40'h3);
        chk("t4 ack",  40'(wr_ack_o), 40'h0);
        sys_rst = 1'b0;
        repeat (12) step();
        chk("t4 no end", 40'(end_q.size()), 40'd0);
        chk("t4 ncmd",   40'(cmd_q.size()), 40'd2);

        // Fresh request after the abort
        run_req(24'h000080, 10'd3, 16'hD000, 20);
        chk("t5 ncmd", 40'(cmd_q.size()), 40'd4);
        chk_ev("t5 act", 0, ev(ACT, 2, 2'd0, 13'h0), 1'b1);
        chk_ev("t5 wr",  1, ev(WRC, 5, 2'd0, 13'h080), 1'b1);
        chk_ev("t5 pre", 3, ev(PRE, 11, 2'd0, 13'h0), 1'b1);
        chk_beat("t5 beat2", 2, 7, 16'hD002);
        chk_end("t5", 14);

        // Wrap from the all-ones address to {0,0,0}
        run_req(24'hFFFFFF, 10'd2, 16'hE000, 28);
        chk("t6 ncmd", 40'(cmd_q.size()), 40'd8);
        chk_ev("t6 act0", 0, ev(ACT, 2, 2'd3, 13'h1FFF), 1'b1);
        chk_ev("t6 wr0",  1, ev(WRC, 5, 2'd3, 13'h1FF), 1'b1);
        chk_ev("t6 bst0", 2, ev(BST, 6, 2'd0, 13'h0), 1'b0);
        chk_ev("t6 pre0", 3, ev(PRE, 9, 2'd3, 13'h0), 1'b1);
        chk_ev("t6 act1", 4, ev(ACT, 12, 2'd0, 13'h0), 1'b1);
        chk_ev("t6 wr1",  5, ev(WRC, 15, 2'd0, 13'h0), 1'b1);
        chk_ev("t6 pre1", 7, ev(PRE, 19, 2'd0, 13'h0), 1'b1);
        chk_beat("t6 beat1", 1, 15, 16'hE001);
        chk("t6 mask", 40'(mask_err), 40'd0);
        chk_end("t6", 22);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
